// File: rtl/eth_downlink_port.sv
// Receive-side frame steering: classifies MAC RX frames by EtherType and pushes
// them to the control, data or forward stream through a one-beat hold register.
module eth_downlink_port #(
    parameter logic [15:0] CTRL_ETYPE = 16'hFF00,
    parameter logic [15:0] FWD_ETYPE  = 16'hFF01
) (
    input  logic        i_data_clk,
    input  logic        i_data_rst,

    input  logic        s_rx_axis_tvalid,
    input  logic [63:0] s_rx_axis_tdata,
    input  logic        s_rx_axis_tlast,
    input  logic [7:0]  s_rx_axis_tkeep,
    input  logic        s_rx_axis_tuser,

    output logic        m_ctrl_axis_tvalid,
    output logic [63:0] m_ctrl_axis_tdata,
    output logic        m_ctrl_axis_tlast,
    output logic [7:0]  m_ctrl_axis_tkeep,
    output logic        m_ctrl_axis_tuser,

    output logic        m_data_axis_tvalid,
    output logic [63:0] m_data_axis_tdata,
    output logic        m_data_axis_tlast,
    output logic [7:0]  m_data_axis_tkeep,
    output logic        m_data_axis_tuser,

    output logic        m_forward_axis_tvalid,
    output logic [63:0] m_forward_axis_tdata,
    output logic        m_forward_axis_tlast,
    output logic [7:0]  m_forward_axis_tkeep,
    output logic        m_forward_axis_tuser,

    input  logic        i_fwd_en,

    output logic [15:0] o_ctrl_pkt_cnt,
    output logic [15:0] o_data_pkt_cnt,
    output logic [15:0] o_fwd_pkt_cnt,
    output logic [15:0] o_drop_pkt_cnt
);

    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HDR, ST_BODY} state_t;
    typedef enum logic [1:0] {RT_DATA, RT_CTRL, RT_FWD, RT_DROP} route_t;

    state_t      state_q, state_d;
    route_t      route_q, route_d;
    route_t      hdr_route;
    route_t      emit_route;
    logic        load;

    logic        h_vld_q, h_vld_d;
    logic [63:0] h_data_q, h_data_d;
    logic [7:0]  h_keep_q, h_keep_d;
    logic        h_last_q, h_last_d;
    logic        h_user_q, h_user_d;

    // out_vld bit 0 = control, 1 = data, 2 = forward
    logic [2:0]  out_vld_q, out_vld_d;
    logic [63:0] out_data_q, out_data_d;
    logic [7:0]  out_keep_q, out_keep_d;
    logic        out_last_q, out_last_d;
    logic        out_user_q, out_user_d;

    logic [15:0] ctrl_cnt_q, ctrl_cnt_d;
    logic [15:0] data_cnt_q, data_cnt_d;
    logic [15:0] fwd_cnt_q, fwd_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        if (s_rx_axis_tdata[31:16] == CTRL_ETYPE) begin
            hdr_route = RT_CTRL;
        end else if (s_rx_axis_tdata[31:16] == FWD_ETYPE) begin
            hdr_route = i_fwd_en ? RT_FWD : RT_DROP;
        end else begin
            hdr_route = RT_DATA;
        end
    end

    always_comb begin
        state_d    = state_q;
        route_d    = route_q;
        load       = 1'b0;
        h_vld_d    = h_vld_q;
        h_data_d   = h_data_q;
        h_keep_d   = h_keep_q;
        h_last_d   = h_last_q;
        h_user_d   = h_user_q;
        out_vld_d  = 3'b000;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;
        out_user_d = out_user_q;
        ctrl_cnt_d = ctrl_cnt_q;
        data_cnt_d = data_cnt_q;
        fwd_cnt_d  = fwd_cnt_q;
        drop_cnt_d = drop_cnt_q;

        // Beat 0 leaves H in the same cycle beat 1 decides the route.
        emit_route = (state_q == ST_HDR) ? hdr_route : route_q;

        if (h_vld_q && (h_last_q || s_rx_axis_tvalid)) begin
            h_vld_d = 1'b0;
            if (emit_route != RT_DROP) begin
                out_data_d = h_data_q;
                out_keep_d = h_keep_q;
                out_last_d = h_last_q;
                out_user_d = h_user_q;
                case (emit_route)
                    RT_CTRL: begin
                        out_vld_d[0] = 1'b1;
                        if (h_last_q) ctrl_cnt_d = ctrl_cnt_q + 16'd1;
                    end
                    RT_DATA: begin
                        out_vld_d[1] = 1'b1;
                        if (h_last_q) data_cnt_d = data_cnt_q + 16'd1;
                    end
                    RT_FWD: begin
                        out_vld_d[2] = 1'b1;
                        if (h_last_q) fwd_cnt_d = fwd_cnt_q + 16'd1;
                    end
                    default: ;
                endcase
            end
        end

        case (state_q)
            ST_SYNC: begin
                if (!s_rx_axis_tvalid || s_rx_axis_tlast) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (s_rx_axis_tvalid) begin
                    if (s_rx_axis_tlast) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (s_rx_axis_tvalid) begin
                    load    = 1'b1;
                    route_d = hdr_route;
                    if (s_rx_axis_tlast) begin
                        state_d = ST_IDLE;
                        if (hdr_route == RT_DROP) drop_cnt_d = drop_cnt_q + 16'd1;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (s_rx_axis_tvalid) begin
                    load = 1'b1;
                    if (s_rx_axis_tlast) begin
                        state_d = ST_IDLE;
                        if (route_q == RT_DROP) drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_SYNC;
        endcase

        if (load) begin
            h_vld_d  = 1'b1;
            h_data_d = s_rx_axis_tdata;
            h_keep_d = s_rx_axis_tkeep;
            h_last_d = s_rx_axis_tlast;
            h_user_d = s_rx_axis_tuser;
        end
    end

    always_ff @(posedge i_data_clk) begin
        if (i_data_rst) begin
            state_q    <= ST_SYNC;
            route_q    <= RT_DATA;
            h_vld_q    <= 1'b0;
            h_data_q   <= 64'd0;
            h_keep_q   <= 8'h00;
            h_last_q   <= 1'b0;
            h_user_q   <= 1'b0;
            out_vld_q  <= 3'b000;
            out_data_q <= 64'd0;
            out_keep_q <= 8'h00;
            out_last_q <= 1'b0;
            out_user_q <= 1'b0;
            ctrl_cnt_q <= 16'd0;
            data_cnt_q <= 16'd0;
            fwd_cnt_q  <= 16'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            route_q    <= route_d;
            h_vld_q    <= h_vld_d;
            h_data_q   <= h_data_d;
            h_keep_q   <= h_keep_d;
            h_last_q   <= h_last_d;
            h_user_q   <= h_user_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
            out_last_q <= out_last_d;
            out_user_q <= out_user_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            data_cnt_q <= data_cnt_d;
            fwd_cnt_q  <= fwd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign m_ctrl_axis_tvalid    = out_vld_q[0];
    assign m_ctrl_axis_tdata     = out_data_q;
    assign m_ctrl_axis_tkeep     = out_keep_q;
    assign m_ctrl_axis_tlast     = out_vld_q[0] & out_last_q;
    assign m_ctrl_axis_tuser     = out_vld_q[0] & out_user_q;

    assign m_data_axis_tvalid    = out_vld_q[1];
    assign m_data_axis_tdata     = out_data_q;
    assign m_data_axis_tkeep     = out_keep_q;
    assign m_data_axis_tlast     = out_vld_q[1] & out_last_q;
    assign m_data_axis_tuser     = out_vld_q[1] & out_user_q;

    assign m_forward_axis_tvalid = out_vld_q[2];
    assign m_forward_axis_tdata  = out_data_q;
    assign m_forward_axis_tkeep  = out_keep_q;
    assign m_forward_axis_tlast  = out_vld_q[2] & out_last_q;
    assign m_forward_axis_tuser  = out_vld_q[2] & out_user_q;

    assign o_ctrl_pkt_cnt = ctrl_cnt_q;
    assign o_data_pkt_cnt = data_cnt_q;
    assign o_fwd_pkt_cnt  = fwd_cnt_q;
    assign o_drop_pkt_cnt = drop_cnt_q;

endmodule
